ssr_capture_ctrl: RTL and testbench

Parametrised capture and decision controller for the speech-recognition datapath. It sits between the ADC sample source and the feature/classifier chain, and replaces the free-running front end and fixed single-LED output logic. On a button press it arms and buffers ADC samples into overlapping frames, then streams each frame to feature extraction over a valid/ready handshake. It collects one classifier result per frame, and drives a one-hot class indication that persists until the next arm.

---
 rtl/ssr_capture_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_ssr_capture_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssr_capture_ctrl.sv
// Button-armed ADC capture into overlapping frames, streamed over valid/ready, with a per-window class decision.
// Build option: define SSR_VOTE_EN for a majority vote over the window; otherwise leds follow the latest result.
module ssr_capture_ctrl #(
  parameter int SAMPLE_W      = 12,
  parameter int FRAME_LEN     = 256,
  parameter int HOP           = 128,
  parameter int WINDOW_FRAMES = 8,
  parameter int N_CLASSES     = 4,
  parameter int CLASS_W       = $clog2(N_CLASSES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 but,
  input  logic                 sample_valid,
  input  logic [SAMPLE_W-1:0]  sample_data,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [SAMPLE_W-1:0]  frame_data,
  output logic                 frame_last,
  input  logic                 class_valid,
  input  logic [CLASS_W-1:0]   class_id,
  output logic [N_CLASSES-1:0] leds,
  output logic                 busy,
  output logic                 overrun
);

  // state    | meaning
  // IDLE     | waiting for the first arm after reset
  // FILL     | buffering the first FRAME_LEN samples of the window
  // STREAM   | emitting one frame from base, still buffering samples
  // HOP_WAIT | waiting until a full frame is unreleased past the new base
  // DRAIN    | all frames sent, waiting for the remaining classifier results
  // SHOW     | decision displayed until the next arm
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_STREAM, S_HOP_WAIT, S_DRAIN, S_SHOW
  } state_t;

  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int UW    = $clog2(DEPTH + 1);
  localparam int FW    = $clog2(FRAME_LEN + 1);
  localparam int WW    = $clog2(WINDOW_FRAMES + 1);

  state_t state, state_nxt;

  logic but_s1, but_s2, but_d;
  logic arm;

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] base;
  logic [AW-1:0] rd_addr;
  logic [UW-1:0] unread;
  logic [FW-1:0] rd_cnt;
  logic [WW-1:0] frames_sent;
  logic [WW-1:0] results;

  logic accepting, collecting, full;
  logic write_en, drop, load, hs, last_hs;
  logic result_en, in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      but_s1 <= 1'b0;
      but_s2 <= 1'b0;
      but_d  <= 1'b0;
    end else begin
      but_s1 <= but;
      but_s2 <= but_s1;
      but_d  <= but_s2;
    end
  end

  assign arm        = but_s2 && !but_d;
  assign accepting  = state inside {S_FILL, S_STREAM, S_HOP_WAIT};
  assign collecting = state inside {S_FILL, S_STREAM, S_HOP_WAIT, S_DRAIN};
  assign full       = (unread == UW'(DEPTH));
  assign write_en   = sample_valid && accepting && !full && !arm;
  assign drop       = sample_valid && accepting && full && !arm;
  assign hs         = frame_valid && frame_ready;
  assign last_hs    = hs && frame_last;
  assign load       = (state == S_STREAM) && (rd_cnt < FW'(FRAME_LEN)) && (!frame_valid || frame_ready);
  assign rd_addr    = base + AW'(rd_cnt);
  assign result_en  = class_valid && collecting;
  assign in_range   = 32'(class_id) < 32'(N_CLASSES);
  assign busy       = (state != S_IDLE) && (state != S_SHOW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = S_FILL;
    end else begin
      case (state)
        S_IDLE:     state_nxt = S_IDLE;
        S_FILL:     if (unread >= UW'(FRAME_LEN)) state_nxt = S_STREAM;
        S_STREAM:   if (last_hs) state_nxt = (frames_sent == WW'(WINDOW_FRAMES - 1)) ? S_DRAIN : S_HOP_WAIT;
        S_HOP_WAIT: if (unread >= UW'(FRAME_LEN)) state_nxt = S_STREAM;
        S_DRAIN:    if (results >= WW'(WINDOW_FRAMES)) state_nxt = S_SHOW;
        S_SHOW:     state_nxt = S_SHOW;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  // The write slot is always at least FRAME_LEN ahead of base, so it never collides with the read window.
  always_ff @(posedge clk) begin
    if (write_en) mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      base        <= '0;
      unread      <= '0;
      rd_cnt      <= '0;
      frames_sent <= '0;
      results     <= '0;
      overrun     <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_last  <= 1'b0;
    end else if (arm) begin
      wr_ptr      <= '0;
      base        <= '0;
      unread      <= '0;
      rd_cnt      <= '0;
      frames_sent <= '0;
      results     <= '0;
      overrun     <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_last  <= 1'b0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + AW'(1);
      if (drop) overrun <= 1'b1;
      unread <= unread + UW'(write_en) - (last_hs ? UW'(HOP) : '0);

      if (load) begin
        frame_data  <= mem[rd_addr];
        frame_last  <= (rd_cnt == FW'(FRAME_LEN - 1));
        frame_valid <= 1'b1;
        rd_cnt      <= rd_cnt + FW'(1);
      end else if (hs) begin
        frame_valid <= 1'b0;
        frame_last  <= 1'b0;
      end

      if (last_hs) begin
        rd_cnt      <= '0;
        base        <= base + AW'(HOP);
        frames_sent <= frames_sent + WW'(1);
      end

      if (result_en && (results != WW'(WINDOW_FRAMES))) results <= results + WW'(1);
    end
  end

`ifdef SSR_VOTE_EN
  logic [WW-1:0]      votes [N_CLASSES];
  logic [CLASS_W-1:0] best_idx;
  logic [WW-1:0]      best_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CLASSES; i++) votes[i] <= '0;
    end else if (arm) begin
      for (int i = 0; i < N_CLASSES; i++) votes[i] <= '0;
    end else if (result_en && in_range && (votes[class_id] != '1)) begin
      votes[class_id] <= votes[class_id] + WW'(1);
    end
  end

  // Strict compare keeps the lowest index on a tie; zero votes leaves best_cnt at 0.
  always_comb begin
    best_idx = '0;
    best_cnt = '0;
    for (int i = 0; i < N_CLASSES; i++) begin
      if (votes[i] > best_cnt) begin
        best_cnt = votes[i];
        best_idx = CLASS_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      leds <= '0;
    else if (arm)
      leds <= '0;
    else if ((state == S_DRAIN) && (state_nxt == S_SHOW))
      leds <= (best_cnt == '0) ? '0 : (N_CLASSES'(1) << best_idx);
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      leds <= '0;
    else if (arm)
      leds <= '0;
    else if (result_en && in_range)
      leds <= N_CLASSES'(1) << class_id;
  end
`endif

endmodule

// File: tb/tb_ssr_capture_ctrl.sv
// Self-checking bench for ssr_capture_ctrl: two instances (4 and 3 classes) share all stimulus.
module tb_ssr_capture_ctrl;
  localparam int SW   = 12;
  localparam int FL   = 8;
  localparam int HOP  = 4;
  localparam int WF   = 3;
  localparam int NC   = 4;
  localparam int NC3  = 3;
  localparam int CW   = 2;
  localparam int NTOT = (WF - 1) * HOP + FL;

  logic clk = 1'b0;
  logic rst, but, sample_valid, frame_ready, class_valid;
  logic [SW-1:0] sample_data;
  logic [CW-1:0] class_id;
  logic frame_valid, frame_last, busy, overrun;
  logic [SW-1:0] frame_data;
  logic [NC-1:0] leds;
  logic fv3, fl3, busy3, ovr3;
  logic [SW-1:0] fd3;
  logic [NC3-1:0] leds3;

  int tests = 0;
  int fails = 0;
  logic [SW-1:0] samp_q[$];
  int cls_q[$];

  always #5 clk = ~clk;

  ssr_capture_ctrl #(.SAMPLE_W(SW), .FRAME_LEN(FL), .HOP(HOP), .WINDOW_FRAMES(WF),
                     .N_CLASSES(NC), .CLASS_W(CW)) u_dut (
    .clk(clk), .rst(rst), .but(but), .sample_valid(sample_valid), .sample_data(sample_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .frame_last(frame_last), .class_valid(class_valid), .class_id(class_id),
    .leds(leds), .busy(busy), .overrun(overrun));

  ssr_capture_ctrl #(.SAMPLE_W(SW), .FRAME_LEN(FL), .HOP(HOP), .WINDOW_FRAMES(WF),
                     .N_CLASSES(NC3), .CLASS_W(CW)) u_dut3 (
    .clk(clk), .rst(rst), .but(but), .sample_valid(sample_valid), .sample_data(sample_data),
    .frame_valid(fv3), .frame_ready(frame_ready), .frame_data(fd3),
    .frame_last(fl3), .class_valid(class_valid), .class_id(class_id),
    .leds(leds3), .busy(busy3), .overrun(ovr3));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Majority over in-range ids, lowest index on ties, 0 when nothing voted.
  function automatic int vote_leds(input int n);
    int cnt[8];
    int best;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    foreach (cls_q[k]) if (cls_q[k] < n) cnt[cls_q[k]]++;
    best = -1;
    for (int c = 0; c < n; c++)
      if (cnt[c] > 0 && (best < 0 || cnt[c] > cnt[best])) best = c;
    return (best < 0) ? 0 : (1 << best);
  endfunction

  // One-hot of the latest in-range id among the first upto results.
  function automatic int last_leds(input int n, input int upto);
    int r;
    r = 0;
    for (int k = 0; k < upto; k++) if (cls_q[k] < n) r = 1 << cls_q[k];
    return r;
  endfunction

  task automatic arm(input string name);
    but = 1'b1;
    tick(); tick(); tick();
    tests++;
    if (busy !== 1'b1 || busy3 !== 1'b1) begin
      fails++;
      $display("FAIL %s arm_busy: busy=%b busy3=%b required 1", name, busy, busy3);
    end
    but = 1'b0;
  endtask

  task automatic send_samples(input int gap_max);
    foreach (samp_q[i]) begin
      repeat ($urandom_range(0, gap_max)) tick();
      sample_valid = 1'b1;
      sample_data  = samp_q[i];
      tick();
      sample_valid = 1'b0;
    end
  endtask

  task automatic collect(input int ready_pct, input string name);
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] held_d;
    logic held_l, stalled, exp_last;
    int beat, cyc;
    for (int k = 0; k < WF; k++)
      for (int j = 0; j < FL; j++) exp_q.push_back(samp_q[k * HOP + j]);
    beat = 0; cyc = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    while (beat < WF * FL && cyc < 3000) begin
      frame_ready = ($urandom_range(0, 99) < ready_pct);
      if (stalled) begin
        tests++;
        if (frame_valid !== 1'b1 || frame_data !== held_d || frame_last !== held_l) begin
          fails++;
          $display("FAIL %s stall_hold beat %0d: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   name, beat, frame_valid, frame_data, frame_last, held_d, held_l);
        end
      end
      if (frame_valid && frame_ready) begin
        exp_last = ((beat % FL) == FL - 1);
        tests++;
        if (frame_data !== exp_q[beat] || fd3 !== exp_q[beat]) begin
          fails++;
          $display("FAIL %s beat_data %0d: got %h/%h required %h", name, beat, frame_data, fd3, exp_q[beat]);
        end
        tests++;
        if (frame_last !== exp_last || fl3 !== exp_last) begin
          fails++;
          $display("FAIL %s beat_last %0d: got %b/%b required %b", name, beat, frame_last, fl3, exp_last);
        end
        beat++;
      end
      stalled = frame_valid && !frame_ready;
      held_d  = frame_data;
      held_l  = frame_last;
      tick();
      cyc++;
    end
    frame_ready = 1'b0;
    tests++;
    if (beat != WF * FL) begin
      fails++;
      $display("FAIL %s stream_timeout: got %0d beats required %0d", name, beat, WF * FL);
    end
  endtask

  task automatic send_results(input string name);
    logic [NC-1:0]  e4;
    logic [NC3-1:0] e3;
    foreach (cls_q[k]) begin
      class_valid = 1'b1;
      class_id    = CW'(cls_q[k]);
      tick();
      class_valid = 1'b0;
`ifdef SSR_VOTE_EN
      e4 = '0;
      e3 = '0;
`else
      e4 = NC'(last_leds(NC, k + 1));
      e3 = NC3'(last_leds(NC3, k + 1));
`endif
      tests++;
      if (leds !== e4 || leds3 !== e3) begin
        fails++;
        $display("FAIL %s interim_leds %0d: got %b/%b required %b/%b", name, k, leds, leds3, e4, e3);
      end
      tick();
    end
  endtask

  task automatic finish_window(input string name);
    logic [NC-1:0]  e4;
    logic [NC3-1:0] e3;
    int cyc;
`ifdef SSR_VOTE_EN
    e4 = NC'(vote_leds(NC));
    e3 = NC3'(vote_leds(NC3));
`else
    e4 = NC'(last_leds(NC, cls_q.size()));
    e3 = NC3'(last_leds(NC3, cls_q.size()));
`endif
    cyc = 0;
    while ((busy !== 1'b0 || busy3 !== 1'b0) && cyc < 200) begin
      tick();
      cyc++;
    end
    tests++;
    if (busy !== 1'b0 || busy3 !== 1'b0) begin
      fails++;
      $display("FAIL %s show_timeout: busy=%b busy3=%b required 0", name, busy, busy3);
    end
    tick();
    tests++;
    if (leds !== e4 || leds3 !== e3 || frame_valid !== 1'b0 || fv3 !== 1'b0) begin
      fails++;
      $display("FAIL %s final_leds: got %b/%b fv=%b required %b/%b fv=0", name, leds, leds3, frame_valid, e4, e3);
    end
    class_valid = 1'b1;
    class_id    = CW'(0);
    tick();
    class_valid = 1'b0;
    tick();
    tests++;
    if (leds !== e4 || leds3 !== e3) begin
      fails++;
      $display("FAIL %s show_hold: got %b/%b required %b/%b", name, leds, leds3, e4, e3);
    end
  endtask

  task automatic window_body(input string name, input int ready_pct, input int gap_max);
    fork
      send_samples(gap_max);
      collect(ready_pct, name);
    join
    send_results(name);
    finish_window(name);
  endtask

  task automatic test_reset();
    rst = 1'b0; but = 1'b0; sample_valid = 1'b0; sample_data = '0;
    frame_ready = 1'b0; class_valid = 1'b0; class_id = '0;
    for (int i = 0; i < 6; i++) begin
      but = ~but;
      tick();
    end
    tests++;
    if (frame_valid !== 1'b0 || frame_data !== '0 || frame_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_frame: valid=%b data=%h last=%b required 0", frame_valid, frame_data, frame_last);
    end
    tests++;
    if (leds !== '0 || leds3 !== '0) begin
      fails++;
      $display("FAIL reset_leds: got %b/%b required 0", leds, leds3);
    end
    tests++;
    if (busy !== 1'b0 || overrun !== 1'b0 || ovr3 !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: busy=%b overrun=%b/%b required 0", busy, overrun, ovr3);
    end
    but = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    but = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests++;
      if (busy !== (c == 3)) begin
        fails++;
        $display("FAIL reset_arm_latency cycle %0d: busy=%b required %b", c, busy, (c == 3));
      end
    end
    but = 1'b0;
    tick(); tick();
  endtask

  task automatic test_framing();
    samp_q.delete();
    for (int i = 0; i < NTOT; i++) samp_q.push_back(SW'(i));
    cls_q = '{2, 1, 2};
    arm("framing");
    window_body("framing", 100, 0);
  endtask

  task automatic test_backpressure();
    samp_q.delete();
    for (int i = 0; i < NTOT; i++) samp_q.push_back(SW'(i));
    cls_q = '{1, 3, 2};
    arm("backpressure");
    window_body("backpressure", 45, 2);
  endtask

  task automatic test_voting();
    samp_q.delete();
    for (int i = 0; i < NTOT; i++) samp_q.push_back(SW'($urandom_range(0, 4095)));
    cls_q = '{3, 3, 3};
    arm("voting_oor");
    window_body("voting_oor", 100, 1);
  endtask

  task automatic test_random();
    for (int w = 0; w < 4; w++) begin
      samp_q.delete();
      for (int i = 0; i < NTOT; i++) samp_q.push_back(SW'($urandom_range(0, 4095)));
      cls_q.delete();
      for (int k = 0; k < WF; k++) cls_q.push_back($urandom_range(0, 3));
      arm("random");
      window_body("random", $urandom_range(20, 100), $urandom_range(0, 3));
    end
  endtask

  task automatic test_overrun();
    samp_q.delete();
    for (int i = 0; i < 2 * FL; i++) samp_q.push_back(SW'($urandom_range(0, 4095)));
    cls_q = '{0, 1, 1};
    arm("overrun");
    frame_ready = 1'b0;
    for (int i = 0; i <= 2 * FL; i++) begin
      sample_valid = 1'b1;
      sample_data  = (i < 2 * FL) ? samp_q[i] : SW'(12'hfff);
      if (i == 2 * FL) begin
        tests++;
        if (overrun !== 1'b0 || ovr3 !== 1'b0) begin
          fails++;
          $display("FAIL overrun_early: got %b/%b required 0", overrun, ovr3);
        end
      end
      tick();
    end
    sample_valid = 1'b0;
    tests++;
    if (overrun !== 1'b1 || ovr3 !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: got %b/%b required 1", overrun, ovr3);
    end
    collect(100, "overrun");
    send_results("overrun");
    finish_window("overrun");
    arm("overrun_clear");
    tests++;
    if (overrun !== 1'b0 || ovr3 !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clear: got %b/%b required 0", overrun, ovr3);
    end
  endtask

  task automatic test_abort();
    logic [NC-1:0]  e4;
    logic [NC3-1:0] e3;
    samp_q.delete();
    for (int i = 0; i < 12; i++) samp_q.push_back(SW'($urandom_range(0, 4095)));
    arm("abort_pre");
    frame_ready = 1'b0;
    send_samples(0);
    class_valid = 1'b1;
    class_id    = CW'(2);
    tick();
    class_valid = 1'b0;
    tick();
`ifdef SSR_VOTE_EN
    e4 = '0;
    e3 = '0;
`else
    e4 = 4'b0100;
    e3 = 3'b100;
`endif
    tests++;
    if (frame_valid !== 1'b1 || leds !== e4 || leds3 !== e3) begin
      fails++;
      $display("FAIL abort_pre_state: fv=%b leds=%b/%b required fv=1 leds=%b/%b", frame_valid, leds, leds3, e4, e3);
    end
    arm("abort");
    tests++;
    if (frame_valid !== 1'b0 || fv3 !== 1'b0 || leds !== '0 || leds3 !== '0) begin
      fails++;
      $display("FAIL abort_clear: fv=%b/%b leds=%b/%b required fv=0 leds=0", frame_valid, fv3, leds, leds3);
    end
    samp_q.delete();
    for (int i = 0; i < NTOT; i++) samp_q.push_back(SW'(12'h800 + i));
    cls_q = '{3, 0, 3};
    window_body("abort_post", 70, 1);
  endtask

  initial begin
    test_reset();
    test_framing();
    test_backpressure();
    test_voting();
    test_random();
    test_overrun();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
